// File: rtl/sample_feeder.sv
// sample_feeder: buffers raw signed 10-bit samples in a small FIFO, clips them
// to signed 8 bits and streams one per cycle to the running min/max/average
// block, closing each frame with a one-cycle RESTART pulse.
module sample_feeder #(
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [9:0] IN_DATA,
  input  logic       IN_LAST,
  input  logic       MODE_AVG,
  output logic [7:0] DATA_IN,
  output logic       ENABLE,
  output logic       RESTART,
  output logic       AVERAGE,
  output logic [7:0] SAT_CNT
);

  localparam int DATA_W = 10;
  localparam int OUT_W  = 8;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = AW + 1;
  localparam int FW     = $clog2(FRAME_LEN + 1);

  localparam logic signed [DATA_W-1:0] SMAX = 127;
  localparam logic signed [DATA_W-1:0] SMIN = -128;

  typedef enum logic {STREAM, RST_PULSE} state_t;

  // Clip a raw sample into the signed 8-bit output range.
  function automatic logic [OUT_W-1:0] sat8(input logic signed [DATA_W-1:0] x);
    if (x > SMAX)      return 8'h7F;
    else if (x < SMIN) return 8'h80;
    else               return x[OUT_W-1:0];
  endfunction

  // True when the raw sample lies outside the signed 8-bit range.
  function automatic logic clipped(input logic signed [DATA_W-1:0] x);
    return (x > SMAX) || (x < SMIN);
  endfunction

  logic [OUT_W:0]             mem [DEPTH];
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              count;
  state_t                     state, state_nx;
  logic [FW-1:0]              frame_cnt, frame_nx;
  logic signed [DATA_W-1:0]   in_data_s;
  logic [OUT_W:0]             head;
  logic                       push, pop;
  logic [OUT_W-1:0]           data_nx;
  logic                       en_nx, rst_nx, avg_nx;

  assign in_data_s = IN_DATA;
  assign IN_READY  = (count != CW'(DEPTH));
  assign push      = IN_VALID && IN_READY;
  assign pop       = (state == STREAM) && (count != '0);
  assign head      = mem[rd_ptr];

  // FIFO storage: entries carry {last, clipped sample}; data needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {IN_LAST, sat8(in_data_s)};
  end

  // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Saturation counter, sticky at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) SAT_CNT <= '0;
    else if (push && clipped(in_data_s) && (SAT_CNT != 8'hFF)) SAT_CNT <= SAT_CNT + 8'd1;
  end

  // State, frame position and registered downstream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= STREAM;
      frame_cnt <= '0;
      DATA_IN   <= '0;
      ENABLE    <= 1'b0;
      RESTART   <= 1'b0;
      AVERAGE   <= 1'b0;
    end else begin
      state     <= state_nx;
      frame_cnt <= frame_nx;
      DATA_IN   <= data_nx;
      ENABLE    <= en_nx;
      RESTART   <= rst_nx;
      AVERAGE   <= avg_nx;
    end
  end

  // Next state and next output values; a frame closes on IN_LAST or at FRAME_LEN.
  always_comb begin
    state_nx = state;
    frame_nx = frame_cnt;
    data_nx  = DATA_IN;
    en_nx    = 1'b0;
    rst_nx   = 1'b0;
    avg_nx   = AVERAGE;
    case (state)
      STREAM: begin
        if (pop) begin
          data_nx = head[OUT_W-1:0];
          en_nx   = 1'b1;
          if (frame_cnt == '0) avg_nx = MODE_AVG;
          if (head[OUT_W] || (frame_cnt == FW'(FRAME_LEN - 1))) begin
            state_nx = RST_PULSE;
            frame_nx = '0;
          end else begin
            frame_nx = frame_cnt + FW'(1);
          end
        end
      end
      RST_PULSE: begin
        rst_nx   = 1'b1;
        state_nx = STREAM;
      end
      default: state_nx = STREAM;
    endcase
  end

endmodule

// File: tb/tb_sample_feeder.sv
// Bench for sample_feeder: directed and random stimulus compared cycle by cycle
// against a queue-based reference model of the feeder's behaviour.
module tb_sample_feeder;

  localparam int DEPTH     = 4;
  localparam int FRAME_LEN = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [9:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       mode_avg = 1'b0;
  logic       IN_READY, ENABLE, RESTART, AVERAGE;
  logic [7:0] DATA_IN, SAT_CNT;

  always #5 clk = ~clk;

  sample_feeder #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .IN_VALID(in_valid), .IN_READY(IN_READY),
    .IN_DATA(in_data), .IN_LAST(in_last), .MODE_AVG(mode_avg),
    .DATA_IN(DATA_IN), .ENABLE(ENABLE), .RESTART(RESTART),
    .AVERAGE(AVERAGE), .SAT_CNT(SAT_CNT)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of buffered entries (last*256 + byte) plus frame bookkeeping.
  int q[$];
  bit m_pend;
  int m_pos;
  int m_dout;
  bit m_en, m_rst, m_avg;
  int m_sat;

  // Observed frame lengths (ENABLEs between RESTARTs).
  int en_run;
  int fl_q[$];

  function automatic int sval(input logic [9:0] d);
    return d[9] ? int'(d) - 1024 : int'(d);
  endfunction

  function automatic int sat_ref(input logic [9:0] d);
    int v;
    v = sval(d);
    if (v > 127)  return 127;
    if (v < -128) return 128;
    return v & 255;
  endfunction

  function automatic bit clip_ref(input logic [9:0] d);
    int v;
    v = sval(d);
    return (v > 127) || (v < -128);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pend = 0; m_pos = 0; m_dout = 0;
    m_en = 0; m_rst = 0; m_avg = 0; m_sat = 0;
    en_run = 0;
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, ".data_in"},  32'(DATA_IN),  32'(m_dout));
    chk({ph, ".enable"},   32'(ENABLE),   32'(m_en));
    chk({ph, ".restart"},  32'(RESTART),  32'(m_rst));
    chk({ph, ".average"},  32'(AVERAGE),  32'(m_avg));
    chk({ph, ".sat_cnt"},  32'(SAT_CNT),  32'(m_sat));
    chk({ph, ".in_ready"}, 32'(IN_READY), 32'(q.size() != DEPTH));
    if (ENABLE === 1'b1) en_run++;
    if (RESTART === 1'b1) begin
      fl_q.push_back(en_run);
      en_run = 0;
    end
  endtask

  // One clock cycle: drive inputs, advance the model across the edge, compare.
  task automatic cyc(input bit v, input logic [9:0] d, input bit l, input bit m, output bit acc);
    int e;
    in_valid = v; in_data = d; in_last = l; mode_avg = m;
    acc = v && (q.size() != DEPTH);
    if (m_pend) begin
      m_rst = 1; m_en = 0; m_pend = 0;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_dout = e % 256;
      m_en = 1; m_rst = 0;
      if (m_pos == 0) m_avg = m;
      m_pos++;
      if (e >= 256 || m_pos == FRAME_LEN) begin
        m_pend = 1;
        m_pos = 0;
      end
    end else begin
      m_en = 0; m_rst = 0;
    end
    if (acc) begin
      q.push_back((l ? 256 : 0) + sat_ref(d));
      if (clip_ref(d) && m_sat < 255) m_sat++;
    end
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  task automatic send(input logic [9:0] d, input bit l, input bit m);
    bit acc;
    int tries;
    acc = 0; tries = 0;
    while (!acc && tries < 50) begin
      cyc(1'b1, d, l, m, acc);
      tries++;
    end
    chk("send_accepted", 32'(acc), 32'(1));
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 10'd0, 1'b0, 1'b0, acc);
  endtask

  initial begin
    bit saw_full;
    bit have, acc;
    logic [9:0] rd;
    bit rl;

    // Power-on reset, released away from the clock edge.
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_outputs("por");

    // Fill the FIFO with single-sample frames, then reset mid-frame.
    for (int i = 0; i < 5; i++) send(10'(i + 1), 1'b1, 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_async");
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_outputs("rst_release");
    idle(4);

    // Three-sample frame in average mode, in-range values.
    send(10'h005, 1'b0, 1'b1);
    send(10'h3FE, 1'b0, 1'b1);
    send(10'h007, 1'b1, 1'b1);
    idle(4);

    // Clipping both ways plus the exact upper bound.
    send(10'h0C8, 1'b0, 1'b0);
    send(10'h300, 1'b0, 1'b0);
    send(10'h07F, 1'b1, 1'b0);
    idle(4);
    chk("sat_cnt_after_clip", 32'(SAT_CNT), 32'(2));

    // Continuous single-sample frames: output runs at half rate so the FIFO fills.
    saw_full = 0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      send(10'(16 + i), 1'b1, 1'(i & 1));
      if (IN_READY === 1'b0) saw_full = 1;
    end
    idle(2 * DEPTH + 4);
    chk("fifo_filled", 32'(saw_full), 32'(1));

    // Frames limited by FRAME_LEN; mode changes before the second frame starts.
    fl_q.delete();
    for (int i = 0; i < 20; i++) send(10'(i * 3), 1'b0, 1'(i >= 12));
    send(10'h055, 1'b1, 1'b0);
    idle(6);
    chk("forced_frame_len", 32'(fl_q.size() > 0 ? fl_q[0] : -1), 32'(FRAME_LEN));
    chk("tail_frame_len",   32'(fl_q.size() > 1 ? fl_q[1] : -1), 32'(5));

    // Random traffic with a source that holds its sample until accepted.
    have = 0; rd = '0; rl = 0;
    for (int i = 0; i < 400; i++) begin
      if (!have) begin
        have = ($urandom_range(0, 2) != 0);
        rd = 10'($urandom);
        rl = ($urandom_range(0, 3) == 0);
      end
      cyc(have, rd, rl, 1'($urandom_range(0, 1)), acc);
      if (acc) have = 0;
    end
    idle(3 * DEPTH);

    // Long run of out-of-range samples drives the counter into saturation.
    for (int i = 0; i < 300; i++) send(10'h200, 1'b0, 1'b0);
    idle(FRAME_LEN + 4);
    chk("sat_cnt_max", 32'(SAT_CNT), 32'(255));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
